dec_ber_checker: RTL and testbench

//  Downstream checker for the Viterbi decoder: buffers source bytes from the serial test generator and compares them in order against decoded bytes.

---
 rtl/dec_ber_checker.sv | 161 ++++++++++++++++
 tb/tb_dec_ber_checker.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_ber_checker.sv
// Bit-error-rate checker: buffers reference words and compares them with decoded words.
// Optional first-mismatch capture ports are enabled with `define ERR_CAPTURE_EN.
module dec_ber_checker #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SKIP_WORDS  = 2,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ref_valid,
    input  logic [DATA_W-1:0] ref_data,
    input  logic              dec_valid,
    input  logic [DATA_W-1:0] dec_data,
    output logic              chk_valid,
    output logic              chk_err,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  word_err_cnt,
    output logic [CNT_W-1:0]  bit_err_cnt,
    output logic [1:0]        state,
    output logic              lost,
    output logic              ovf,
    output logic              udf
`ifdef ERR_CAPTURE_EN
    ,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_got,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic              first_err_vld
`endif
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int SW  = (SKIP_WORDS > 1) ? $clog2(SKIP_WORDS) : 1;
    localparam int LW  = $clog2(LOSS_THRESH + 1);
    localparam int EW  = $clog2(DATA_W + 1);
    localparam int CW1 = CNT_W + 1;

    localparam logic [1:0] ST_SKIP  = 2'b00;
    localparam logic [1:0] ST_CHECK = 2'b01;
    localparam logic [1:0] ST_LOST  = 2'b10;
    localparam logic [1:0] ST_RESET = (SKIP_WORDS > 0) ? ST_SKIP : ST_CHECK;

    localparam logic [SW-1:0] SKIP_LAST =
        (SKIP_WORDS > 0) ? SW'(SKIP_WORDS - 1) : '0;
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_THRESH - 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [SW-1:0]     skip_cnt;
    logic [LW-1:0]     consec;

    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              cmp;
    logic              mism;
    logic [DATA_W-1:0] head;
    logic [EW-1:0]     nerr;

    function automatic logic [EW-1:0] popcnt(input logic [DATA_W-1:0] x);
        logic [EW-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) c = c + EW'(x[i]);
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v,
                                                 input logic [EW-1:0]    n);
        logic [CNT_W:0] s;
        s = {1'b0, v} + CW1'(n);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // No bypass: an empty FIFO cannot pop even when a push lands this cycle.
    assign pop   = dec_valid && (state != ST_SKIP) && !empty;
    assign push  = ref_valid && (!full || pop);
    assign cmp   = pop && (state == ST_CHECK);
    assign mism  = (head != dec_data);
    assign nerr  = popcnt(head ^ dec_data);
    assign lost  = (state == ST_LOST);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= ref_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            state        <= ST_RESET;
            skip_cnt     <= '0;
            consec       <= '0;
            chk_valid    <= 1'b0;
            chk_err      <= 1'b0;
            word_cnt     <= '0;
            word_err_cnt <= '0;
            bit_err_cnt  <= '0;
            ovf          <= 1'b0;
            udf          <= 1'b0;
        end else begin
            chk_valid <= cmp;
            chk_err   <= cmp && mism;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (ref_valid && !push) ovf <= 1'b1;
            if (dec_valid && (state == ST_CHECK) && empty) udf <= 1'b1;
            unique case (state)
                ST_SKIP: begin
                    if (dec_valid) begin
                        if (skip_cnt == SKIP_LAST) state <= ST_CHECK;
                        else skip_cnt <= skip_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (cmp) begin
                        word_cnt <= sat_inc(word_cnt);
                        if (mism) begin
                            word_err_cnt <= sat_inc(word_err_cnt);
                            bit_err_cnt  <= sat_add(bit_err_cnt, nerr);
                            consec       <= consec + 1'b1;
                            if (consec == LOSS_LAST) state <= ST_LOST;
                        end else begin
                            consec <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ERR_CAPTURE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_err_exp <= '0;
            first_err_got <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else if (cmp && mism && !first_err_vld) begin
            first_err_exp <= head;
            first_err_got <= dec_data;
            first_err_idx <= word_cnt;
            first_err_vld <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dec_ber_checker.sv
// Self-checking bench for dec_ber_checker against a queue-based reference model.
// Capture ports are exercised when ERR_CAPTURE_EN is defined.
module tb_dec_ber_checker;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int SKIP  = 2;
    localparam int LOSS  = 4;
    localparam int CW    = 32;
    localparam longint CMAX = 64'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ref_valid = 1'b0;
    logic [DW-1:0] ref_data = '0;
    logic          dec_valid = 1'b0;
    logic [DW-1:0] dec_data = '0;
    logic          chk_valid;
    logic          chk_err;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] word_err_cnt;
    logic [CW-1:0] bit_err_cnt;
    logic [1:0]    state;
    logic          lost;
    logic          ovf;
    logic          udf;
`ifdef ERR_CAPTURE_EN
    logic [DW-1:0] first_err_exp;
    logic [DW-1:0] first_err_got;
    logic [CW-1:0] first_err_idx;
    logic          first_err_vld;
`endif

    dec_ber_checker #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .SKIP_WORDS(SKIP),
        .LOSS_THRESH(LOSS), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .ref_valid(ref_valid), .ref_data(ref_data),
        .dec_valid(dec_valid), .dec_data(dec_data),
        .chk_valid(chk_valid), .chk_err(chk_err),
        .word_cnt(word_cnt), .word_err_cnt(word_err_cnt),
        .bit_err_cnt(bit_err_cnt), .state(state), .lost(lost),
        .ovf(ovf), .udf(udf)
`ifdef ERR_CAPTURE_EN
        ,
        .first_err_exp(first_err_exp), .first_err_got(first_err_got),
        .first_err_idx(first_err_idx), .first_err_vld(first_err_vld)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a queue plus plain counters.
    logic [DW-1:0] q[$];
    int     m_state;
    int     m_skip;
    int     m_consec;
    longint m_wc, m_wec, m_bec;
    bit     m_ovf, m_udf, m_cv, m_ce;
    bit     m_fvld;
    logic [DW-1:0] m_fexp, m_fgot;
    longint m_fidx;

    function automatic longint sat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_state  = (SKIP > 0) ? 0 : 1;
        m_skip   = 0;
        m_consec = 0;
        m_wc = 0; m_wec = 0; m_bec = 0;
        m_ovf = 0; m_udf = 0; m_cv = 0; m_ce = 0;
        m_fvld = 0; m_fexp = '0; m_fgot = '0; m_fidx = 0;
    endtask

    task automatic model_step(input bit rv, input logic [DW-1:0] rd,
                              input bit dv, input logic [DW-1:0] dd);
        int sz;
        bit popped;
        logic [DW-1:0] h;
        m_cv = 0; m_ce = 0; popped = 0;
        sz = q.size();
        if (dv) begin
            if (m_state == 0) begin
                m_skip++;
                if (m_skip >= SKIP) m_state = 1;
            end else if (sz == 0) begin
                if (m_state == 1) m_udf = 1;
            end else begin
                h = q.pop_front();
                popped = 1;
                if (m_state == 1) begin
                    m_cv = 1;
                    m_ce = (h != dd);
                    if (m_ce) begin
                        if (!m_fvld) begin
                            m_fvld = 1; m_fexp = h; m_fgot = dd; m_fidx = m_wc;
                        end
                        m_wec = sat(m_wec + 1);
                        m_bec = sat(m_bec + $countones(h ^ dd));
                        m_consec++;
                        if (m_consec >= LOSS) m_state = 2;
                    end else begin
                        m_consec = 0;
                    end
                    m_wc = sat(m_wc + 1);
                end
            end
        end
        if (rv) begin
            if (sz < DEPTH || popped) q.push_back(rd);
            else m_ovf = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("chk_valid", 64'(chk_valid), 64'(m_cv));
        chk("chk_err", 64'(chk_err), 64'(m_ce));
        chk("word_cnt", 64'(word_cnt), 64'(m_wc));
        chk("word_err_cnt", 64'(word_err_cnt), 64'(m_wec));
        chk("bit_err_cnt", 64'(bit_err_cnt), 64'(m_bec));
        chk("state", 64'(state), 64'(m_state));
        chk("lost", 64'(lost), 64'(m_state == 2));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("udf", 64'(udf), 64'(m_udf));
`ifdef ERR_CAPTURE_EN
        chk("first_err_vld", 64'(first_err_vld), 64'(m_fvld));
        chk("first_err_exp", 64'(first_err_exp), 64'(m_fexp));
        chk("first_err_got", 64'(first_err_got), 64'(m_fgot));
        chk("first_err_idx", 64'(first_err_idx), 64'(m_fidx));
`endif
    endtask

    task automatic step(input bit rv, input logic [DW-1:0] rd,
                        input bit dv, input logic [DW-1:0] dd);
        @(negedge clk);
        ref_valid = rv; ref_data = rd;
        dec_valid = dv; dec_data = dd;
        @(posedge clk);
        #1;
        model_step(rv, rd, dv, dd);
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        ref_valid = 1'b0;
        dec_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        step(1, d, 0, '0);
    endtask

    task automatic dec(input logic [DW-1:0] d);
        step(0, '0, 1, d);
    endtask

    task automatic drain_clean(input int n);
        for (int i = 0; i < n; i++) dec(q.size() > 0 ? q[0] : 8'h00);
    endtask

    initial begin
        model_reset();
        #12;
        do_reset();

        // Scenario 1: warm-up words dropped, three clean compares.
        push(8'hA5); push(8'h3C); push(8'h0F);
        dec(8'h11); dec(8'h22);
        dec(8'hA5); dec(8'h3C); dec(8'h0F);
        chk("s1_word_cnt", 64'(word_cnt), 64'd3);
        dec(8'h55);
        chk("s1_empty_udf", 64'(udf), 64'd1);

        // Scenario 2: 0xFF vs 0x0E, five bit errors.
        push(8'hFF);
        dec(8'h0E);
        chk("s2_bits", 64'(bit_err_cnt), 64'd5);

        // Scenario 3: clear error run, then four mismatches force LOST.
        push(8'h12); dec(8'h12);
        for (int i = 0; i < LOSS; i++) begin
            push(8'(8'h40 + i));
            dec(8'(8'hC0 + i));
        end
        chk("s3_state", 64'(state), 64'd2);
        push(8'h77); dec(8'h77);
        push(8'h78); push(8'h79);
        dec(8'h00); dec(8'h00);

        // Scenario 4: overflow, then full with simultaneous push/pop.
        do_reset();
        dec(8'h00); dec(8'h00);
        for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom));
        chk("s4_ovf", 64'(ovf), 64'd1);
        step(1, 8'h9E, 1, q[0]);
        drain_clean(DEPTH);
        chk("s4_no_udf", 64'(udf), 64'd0);
        dec(8'h00);

        // Scenario 5: empty FIFO with simultaneous push and pop.
        do_reset();
        dec(8'h00); dec(8'h00);
        step(1, 8'h6B, 1, 8'h6B);
        chk("s5_udf", 64'(udf), 64'd1);
        drain_clean(1);

        // Scenario 6: first-mismatch capture stays on the earliest error.
        do_reset();
        dec(8'h00); dec(8'h00);
        for (int i = 0; i < 7; i++) begin
            push(8'(i * 3)); dec(8'(i * 3));
        end
        push(8'h80); dec(8'h00);
        push(8'h01); dec(8'h01);
        push(8'h33); dec(8'h32);
`ifdef ERR_CAPTURE_EN
        chk("s6_idx", 64'(first_err_idx), 64'd7);
        chk("s6_exp", 64'(first_err_exp), 64'h80);
`endif

        // Random traffic with occasional corrupted decoded words.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit rv, dv;
            logic [DW-1:0] rd, dd;
            rv = 1'($urandom % 2);
            dv = 1'($urandom % 2);
            rd = 8'($urandom);
            if (q.size() > 0 && ($urandom % 12) != 0) dd = q[0];
            else dd = 8'($urandom);
            step(rv, rd, dv, dd);
        end

        // Reset mid-stream with five words queued.
        do_reset();
        dec(8'h00); dec(8'h00);
        for (int i = 0; i < 5; i++) push(8'(8'hD0 + i));
        do_reset();
        chk("s6_state", 64'(state), 64'd0);
        dec(8'h00); dec(8'h00);
        dec(8'hD0);
        chk("s6_flushed", 64'(udf), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
